// File: rtl/midori_sbox_seq.sv
`default_nettype none
// ============================================================================
// Module   : midori_sbox_seq
// Purpose  : Streams 16 shared nibbles through an external masked Midori
//            S-box pipeline, gating it on PRNG availability and reassembling
//            the output shares.
// Revision : 1.0 - initial release
// ============================================================================
module midori_sbox_seq #(
    parameter int STAGES  = 3,
    parameter int NIBBLES = 16,
    parameter int RAND_W  = 33
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   in_s0,
    input  logic [4*NIBBLES-1:0]   in_s1,
    input  logic [4*NIBBLES-1:0]   in_s2,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   out_s0,
    output logic [4*NIBBLES-1:0]   out_s1,
    output logic [4*NIBBLES-1:0]   out_s2,
    input  logic                   rnd_valid,
    input  logic [RAND_W-1:0]      rnd_data,
    output logic                   rnd_ready,
    output logic [3:0]             sb_in_s0,
    output logic [3:0]             sb_in_s1,
    output logic [3:0]             sb_in_s2,
    output logic [RAND_W-1:0]      sb_rnd,
    output logic [STAGES-1:0]      sb_en,
    input  logic [3:0]             sb_out_s0,
    input  logic [3:0]             sb_out_s1,
    input  logic [3:0]             sb_out_s2
);

    localparam int c_IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    logic [4*NIBBLES-1:0] r_in_s0;
    logic [4*NIBBLES-1:0] r_in_s1;
    logic [4*NIBBLES-1:0] r_in_s2;
    logic [4*NIBBLES-1:0] r_out_s0;
    logic [4*NIBBLES-1:0] r_out_s1;
    logic [4*NIBBLES-1:0] r_out_s2;
    logic [c_IDX_W-1:0]   r_ii;
    logic [c_IDX_W-1:0]   r_ci;
    logic [STAGES-1:0]    r_v;

    logic                 w_issue;
    logic                 w_advance;
    logic                 w_capture;
    logic [STAGES-1:0]    w_v_shift;

    always_comb begin
        w_issue      = (r_state == S_RUN) && rnd_valid;
        w_advance    = w_issue || (r_state == S_DRAIN);
        w_capture    = r_v[STAGES-1] && w_advance;
        w_v_shift    = '0;
        w_v_shift[0] = w_issue;
        for (int i = 1; i < STAGES; i++) begin
            w_v_shift[i] = r_v[i-1];
        end
    end

    // Shares and randomness stay at zero unless a fresh word is issued.
    always_comb begin
        sb_in_s0 = '0;
        sb_in_s1 = '0;
        sb_in_s2 = '0;
        sb_rnd   = '0;
        if (w_issue) begin
            sb_in_s0 = r_in_s0[4*r_ii +: 4];
            sb_in_s1 = r_in_s1[4*r_ii +: 4];
            sb_in_s2 = r_in_s2[4*r_ii +: 4];
            sb_rnd   = rnd_data;
        end
    end

    assign sb_en     = {STAGES{w_advance}};
    assign rnd_ready = (r_state == S_RUN);
    assign busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done      = (r_state == S_DONE);
    assign out_s0    = r_out_s0;
    assign out_s1    = r_out_s1;
    assign out_s2    = r_out_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_in_s0  <= '0;
            r_in_s1  <= '0;
            r_in_s2  <= '0;
            r_out_s0 <= '0;
            r_out_s1 <= '0;
            r_out_s2 <= '0;
            r_ii     <= '0;
            r_ci     <= '0;
            r_v      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_in_s0 <= in_s0;
                        r_in_s1 <= in_s1;
                        r_in_s2 <= in_s2;
                        r_ii    <= '0;
                        r_ci    <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_issue) begin
                        r_ii <= r_ii + 1'b1;
                        if (r_ii == c_LAST) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_v_shift == '0) begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // A stall freezes v, so a valid at the tail is captured once.
            if (w_advance) begin
                r_v <= w_v_shift;
            end
            if (w_capture) begin
                r_out_s0[4*r_ci +: 4] <= sb_out_s0;
                r_out_s1[4*r_ci +: 4] <= sb_out_s1;
                r_out_s2[4*r_ci +: 4] <= sb_out_s2;
                r_ci                  <= r_ci + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_midori_sbox_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_midori_sbox_seq
// Purpose  : Directed bench for midori_sbox_seq (STAGES=3 and STAGES=2)
//            against a behavioural masked Sb0 pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module tb_midori_sbox_seq;

    localparam logic [63:0] c_PT0  = 64'h0123456789abcdef;
    localparam logic [63:0] c_CT0  = 64'hcad3ebf789150246;
    localparam logic [63:0] c_PT1  = 64'hfedcba9876543210;
    localparam logic [63:0] c_CT1  = 64'h642051987fbe3dac;
    localparam logic [63:0] c_PTZ  = 64'h0000000000000000;
    localparam logic [63:0] c_CTZ  = 64'hcccccccccccccccc;
    localparam logic [63:0] c_PTF  = 64'hffffffffffffffff;
    localparam logic [63:0] c_CTF  = 64'h6666666666666666;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] in_s0, in_s1, in_s2;
    logic        rnd_valid;
    logic [32:0] rnd_data;

    logic        busy, done, rnd_ready;
    logic [63:0] out_s0, out_s1, out_s2;
    logic [3:0]  sb_in_s0, sb_in_s1, sb_in_s2;
    logic [32:0] sb_rnd;
    logic [2:0]  sb_en;
    logic [3:0]  sb_out_s0, sb_out_s1, sb_out_s2;

    logic        busy2, done2, rnd_ready2;
    logic [63:0] out2_s0, out2_s1, out2_s2;
    logic [3:0]  sb2_in_s0, sb2_in_s1, sb2_in_s2;
    logic [32:0] sb2_rnd;
    logic [1:0]  sb2_en;
    logic [3:0]  sb2_out_s0, sb2_out_s1, sb2_out_s2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    midori_sbox_seq #(.STAGES(3), .NIBBLES(16), .RAND_W(33)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_s0(in_s0), .in_s1(in_s1), .in_s2(in_s2),
        .busy(busy), .done(done),
        .out_s0(out_s0), .out_s1(out_s1), .out_s2(out_s2),
        .rnd_valid(rnd_valid), .rnd_data(rnd_data), .rnd_ready(rnd_ready),
        .sb_in_s0(sb_in_s0), .sb_in_s1(sb_in_s1), .sb_in_s2(sb_in_s2),
        .sb_rnd(sb_rnd), .sb_en(sb_en),
        .sb_out_s0(sb_out_s0), .sb_out_s1(sb_out_s1), .sb_out_s2(sb_out_s2)
    );

    midori_sbox_seq #(.STAGES(2), .NIBBLES(16), .RAND_W(33)) dut2 (
        .clk(clk), .rst(rst), .start(start),
        .in_s0(in_s0), .in_s1(in_s1), .in_s2(in_s2),
        .busy(busy2), .done(done2),
        .out_s0(out2_s0), .out_s1(out2_s1), .out_s2(out2_s2),
        .rnd_valid(rnd_valid), .rnd_data(rnd_data), .rnd_ready(rnd_ready2),
        .sb_in_s0(sb2_in_s0), .sb_in_s1(sb2_in_s1), .sb_in_s2(sb2_in_s2),
        .sb_rnd(sb2_rnd), .sb_en(sb2_en),
        .sb_out_s0(sb2_out_s0), .sb_out_s1(sb2_out_s1), .sb_out_s2(sb2_out_s2)
    );

    function automatic logic [3:0] sb0(input logic [3:0] x);
        case (x)
            4'h0: sb0 = 4'hc; 4'h1: sb0 = 4'ha; 4'h2: sb0 = 4'hd; 4'h3: sb0 = 4'h3;
            4'h4: sb0 = 4'he; 4'h5: sb0 = 4'hb; 4'h6: sb0 = 4'hf; 4'h7: sb0 = 4'h7;
            4'h8: sb0 = 4'h8; 4'h9: sb0 = 4'h9; 4'ha: sb0 = 4'h1; 4'hb: sb0 = 4'h5;
            4'hc: sb0 = 4'h0; 4'hd: sb0 = 4'h2; 4'he: sb0 = 4'h4; default: sb0 = 4'h6;
        endcase
    endfunction

    // Behavioural masked S-box: stage 1 computes and remasks, later stages delay.
    bit [3:0] m1_s0[3], m1_s1[3], m1_s2[3];
    bit [3:0] m2_s0[2], m2_s1[2], m2_s2[2];

    always_ff @(posedge clk) begin
        if (sb_en[0]) begin
            m1_s0[0] <= sb0(sb_in_s0 ^ sb_in_s1 ^ sb_in_s2) ^ sb_rnd[3:0] ^ sb_rnd[12:9];
            m1_s1[0] <= sb_rnd[3:0];
            m1_s2[0] <= sb_rnd[12:9];
        end
        for (int k = 1; k < 3; k++) begin
            if (sb_en[k]) begin
                m1_s0[k] <= m1_s0[k-1];
                m1_s1[k] <= m1_s1[k-1];
                m1_s2[k] <= m1_s2[k-1];
            end
        end
        if (sb2_en[0]) begin
            m2_s0[0] <= sb0(sb2_in_s0 ^ sb2_in_s1 ^ sb2_in_s2) ^ sb2_rnd[3:0] ^ sb2_rnd[12:9];
            m2_s1[0] <= sb2_rnd[3:0];
            m2_s2[0] <= sb2_rnd[12:9];
        end
        if (sb2_en[1]) begin
            m2_s0[1] <= m2_s0[0];
            m2_s1[1] <= m2_s1[0];
            m2_s2[1] <= m2_s2[0];
        end
    end

    assign sb_out_s0  = m1_s0[2];
    assign sb_out_s1  = m1_s1[2];
    assign sb_out_s2  = m1_s2[2];
    assign sb2_out_s0 = m2_s0[1];
    assign sb2_out_s1 = m2_s1[1];
    assign sb2_out_s2 = m2_s2[1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full pass with per-cycle protocol checks; start is raised in cycle 0.
    task automatic do_pass(input string name, input logic [63:0] a0, input logic [63:0] a1,
                           input logic [63:0] a2, input logic [63:0] ct,
                           input bit stalls, input bit extra_starts, input bit rand_rnd,
                           input int exp_cyc);
        int  cyc = 0;
        int  hs = 0;
        int  stall_cnt = 0;
        bit  seen = 0;
        logic [63:0] t;
        logic [3:0]  nib0, nib1;
        in_s0 = a0; in_s1 = a1; in_s2 = a2;
        start = 1'b1; rnd_valid = 1'b0; rnd_data = '0;
        tick();
        start = 1'b0;
        cyc = 1;
        while (cyc <= 200 && !seen) begin
            if (stalls && rnd_ready && (hs == 0 || hs == 7 || hs == 15) && stall_cnt < 5) begin
                rnd_valid = 1'b0;
                stall_cnt++;
            end else begin
                rnd_valid = 1'b1;
            end
            t = {$urandom(), $urandom()};
            rnd_data = rand_rnd ? t[32:0] : 33'd0;
            if (extra_starts && (cyc == 3 || cyc == 18)) begin
                start = 1'b1;
                in_s0 = ~a0;
            end else begin
                start = 1'b0;
            end
            #1;
            n_checks++;
            if (rnd_ready !== (hs < 16)) begin
                n_fail++;
                $display("FAIL %s rnd_ready cyc=%0d: got %b expected %b", name, cyc, rnd_ready, hs < 16);
            end
            n_checks++;
            if (busy !== (cyc < exp_cyc)) begin
                n_fail++;
                $display("FAIL %s busy cyc=%0d: got %b expected %b", name, cyc, busy, cyc < exp_cyc);
            end
            n_checks++;
            if (done2 !== (cyc == exp_cyc - 1)) begin
                n_fail++;
                $display("FAIL %s done2 cyc=%0d: got %b expected %b", name, cyc, done2, cyc == exp_cyc - 1);
            end
            if (rnd_ready && !rnd_valid) begin
                n_checks++;
                if (sb_en !== 3'b000 || {sb_in_s0, sb_in_s1, sb_in_s2} !== 12'h000 || sb_rnd !== 33'd0) begin
                    n_fail++;
                    $display("FAIL %s stall_quiet cyc=%0d: got en=%b in=%h rnd=%h expected all zero",
                             name, cyc, sb_en, {sb_in_s0, sb_in_s1, sb_in_s2}, sb_rnd);
                end
            end
            if (rnd_ready && rnd_valid) begin
                t    = a0 >> (4 * hs);
                nib0 = t[3:0];
                t    = a1 >> (4 * hs);
                nib1 = t[3:0];
                n_checks++;
                if (sb_en !== 3'b111 || sb_in_s0 !== nib0 || sb_in_s1 !== nib1 || sb_rnd !== rnd_data) begin
                    n_fail++;
                    $display("FAIL %s issue hs=%0d: got en=%b s0=%h s1=%h rnd=%h expected en=111 s0=%h s1=%h rnd=%h",
                             name, hs, sb_en, sb_in_s0, sb_in_s1, sb_rnd, nib0, nib1, rnd_data);
                end
                hs++;
            end
            if (rnd_ready && rnd_valid) stall_cnt = 0;
            if (done2) begin
                n_checks++;
                if ((out2_s0 ^ out2_s1 ^ out2_s2) !== ct) begin
                    n_fail++;
                    $display("FAIL %s result_stages2: got %h expected %h", name, out2_s0 ^ out2_s1 ^ out2_s2, ct);
                end
            end
            if (done) begin
                seen = 1;
                n_checks++;
                if (cyc != exp_cyc) begin
                    n_fail++;
                    $display("FAIL %s done_cycle: got %0d expected %0d", name, cyc, exp_cyc);
                end
                n_checks++;
                if ((out_s0 ^ out_s1 ^ out_s2) !== ct) begin
                    n_fail++;
                    $display("FAIL %s result: got %h expected %h", name, out_s0 ^ out_s1 ^ out_s2, ct);
                end
                n_checks++;
                if (hs != 16) begin
                    n_fail++;
                    $display("FAIL %s handshakes: got %0d expected 16", name, hs);
                end
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: got no done expected done at cycle %0d", name, exp_cyc);
        end
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_width: got done=%b busy=%b expected 0 0", name, done, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; rnd_valid = 1'b1; rnd_data = '1;
        in_s0 = c_PT0; in_s1 = '0; in_s2 = '0;
        tick(); tick();
        n_checks++;
        if ({busy, done, rnd_ready, sb_en} !== 6'b0 || (out_s0 | out_s1 | out_s2) !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b done=%b ready=%b en=%b out=%h expected all zero",
                     busy, done, rnd_ready, sb_en, out_s0 | out_s1 | out_s2);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        do_pass("basic", c_PT0, 64'd0, 64'd0, c_CT0, 0, 0, 0, 20);
        do_pass("all_zero", c_PTZ, 64'd0, 64'd0, c_CTZ, 0, 0, 0, 20);
        do_pass("all_ones", c_PTF, 64'd0, 64'd0, c_CTF, 0, 0, 0, 20);
    endtask

    task automatic test_random_masking();
        logic [63:0] m1, m2;
        m1 = {$urandom(), $urandom()};
        m2 = {$urandom(), $urandom()};
        do_pass("masked", c_PT0 ^ m1 ^ m2, m1, m2, c_CT0, 0, 0, 1, 20);
        m1 = {$urandom(), $urandom()};
        m2 = {$urandom(), $urandom()};
        do_pass("masked_pt1", c_PT1 ^ m1 ^ m2, m1, m2, c_CT1, 0, 0, 1, 20);
    endtask

    task automatic test_prng_stalls();
        do_pass("stalls", c_PT0, 64'd0, 64'd0, c_CT0, 1, 0, 1, 35);
    endtask

    task automatic test_start_while_busy();
        do_pass("start_busy", c_PT0, 64'd0, 64'd0, c_CT0, 0, 1, 0, 20);
    endtask

    task automatic test_back_to_back();
        do_pass("b2b_first", c_PT1, 64'd0, 64'd0, c_CT1, 0, 0, 0, 20);
        do_pass("b2b_second", c_PT0, 64'd0, 64'd0, c_CT0, 0, 0, 0, 20);
    endtask

    task automatic test_reset_mid_run();
        in_s0 = c_PT1; in_s1 = '0; in_s2 = '0;
        start = 1'b1; rnd_valid = 1'b1; rnd_data = '0;
        tick();
        start = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || sb_en !== 3'b000 || dut.r_v !== 3'b000 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_ctrl: got busy=%b en=%b v=%b done=%b expected 0 000 000 0",
                     busy, sb_en, dut.r_v, done);
        end
        n_checks++;
        if ((out_s0 | out_s1 | out_s2) !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_mid_out: got %h expected 0", out_s0 | out_s1 | out_s2);
        end
        do_pass("after_reset", c_PT0, 64'd0, 64'd0, c_CT0, 0, 0, 0, 20);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random_masking();
        test_prng_stalls();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
